fft_cmul_combine: RTL and testbench
===================================

FFT_CMUL_COMBINE -- requirements
Module: fft_cmul_combine

Interface
REQ-001 Parameter PWIDTH, default 36, SHALL be the signed width of each incoming partial product.
REQ-002 Parameter OWIDTH, default 18, SHALL be the signed width of each output component.
REQ-003 Parameter SHIFT, default 17, SHALL be the right-shift applied when the accumulated sum is scaled to the output.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-006 Port p_valid, input, 1 bit, SHALL mark p as carrying a partial product this cycle.
REQ-007 Port p_first, input, 1 bit, SHALL mark the current p as term 0 of a complex product.
REQ-008 Port p, input, PWIDTH bits signed, SHALL carry the partial product from the shared multiplier.
REQ-009 Port clr_flags, input, 1 bit, SHALL clear all sticky flags synchronously.
REQ-010 Port o_ready, input, 1 bit, SHALL be the downstream ready signal.
REQ-011 Port o_valid, output, 1 bit, SHALL indicate that o_re and o_im are valid.
REQ-012 Port o_re, output, OWIDTH bits signed, SHALL carry the real part of the result.
REQ-013 Port o_im, output, OWIDTH bits signed, SHALL carry the imaginary part of the result.
REQ-014 Port sat_flag, output, 1 bit, SHALL be a sticky flag set on any saturation.
REQ-015 Port drop_flag, output, 1 bit, SHALL be a sticky flag set when a result is dropped because the FIFO is full.
REQ-016 Port seq_err, output, 1 bit, SHALL be a sticky flag set on a term-sequence error.

Function
REQ-017 The block SHALL accept no backpressure upstream: every cycle with p_valid=1 SHALL consume p.
REQ-018 A phase counter (0..3) SHALL advance only on accepted terms, with terms in this order: 0 = ar*br, 1 = ai*bi, 2 = ar*bi, 3 = ai*br.
REQ-019 Accumulation SHALL use PWIDTH+1-bit signed accumulators, updated as follows:
- term 0 loads acc_re = p.
- term 1 computes acc_re = acc_re - p.
- term 2 loads acc_im = p.
- term 3 computes acc_im = acc_im + p.
REQ-020 A term with p_first=1 SHALL be treated as term 0 regardless of the phase counter.
REQ-021 If p_first=1 arrives while the phase counter is nonzero, the partial result SHALL be discarded and seq_err SHALL be set.
REQ-022 A term with p_first=0 while the phase counter is 0 SHALL be ignored and SHALL set seq_err.
REQ-023 Scaling SHALL compute (acc + 2^(SHIFT-1)) >>> SHIFT using an arithmetic shift (round half up).
REQ-024 The scaled value SHALL then saturate to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1]; any clip of either component SHALL set sat_flag.
REQ-025 Rounding and saturation SHALL be registered; a result SHALL be written to the output FIFO exactly 2 cycles after the term-3 accept cycle.
REQ-026 The output FIFO SHALL be 2 entries deep and in-order, with o_re, o_im and o_valid driven from the head entry.
REQ-027 A pop SHALL occur when o_valid=1 and o_ready=1.
REQ-028 A push and a pop in the same cycle SHALL both succeed at any occupancy, including full.
REQ-029 A push while the FIFO is full with no pop SHALL drop the new result and set drop_flag.
REQ-030 o_re and o_im SHALL hold their value while o_valid=1 and o_ready=0.
REQ-031 Sticky flags SHALL stay set until clr_flags=1.
REQ-032 If clr_flags=1 coincides with a flag-setting event, the flag SHALL end the cycle set.
REQ-033 When the phase counter wraps 3 -> 0, the accumulators SHALL be reusable on the next cycle, so back-to-back products at 1 term per cycle SHALL be sustained.

Reset
REQ-034 While rst=0, the following SHALL be cleared asynchronously:
- phase counter = 0
- accumulators = 0
- FIFO empty
- o_valid = 0
- o_re = 0, o_im = 0
- sat_flag, drop_flag and seq_err = 0
REQ-035 A reset mid-product SHALL discard the partial result, and no output SHALL appear from pre-reset terms.
REQ-036 Deassertion of reset SHALL be synchronous to clk, and the first term SHALL be accepted on the first rising edge with rst=1.

Verification (PWIDTH=36, OWIDTH=18, SHIFT=17)
REQ-037 The bench SHALL check the nominal case: terms 2^32, 0, 0, 0 with o_ready=1 -> o_re=32768, o_im=0, o_valid high 2 cycles after term 3, flags 0.
REQ-038 The bench SHALL check rounding:
- acc_re = 2^16 (terms 2^16, 0) -> o_re = 1.
- acc_re = 2^16-1 -> o_re = 0.
- acc_re = -2^16 -> o_re = 0.
- acc_im = -2^16-1 -> o_im = -1.
REQ-039 The bench SHALL check saturation:
- terms 2^34, 0, -2^34, -2^19 -> o_re = 131071, o_im = -131072, sat_flag = 1.
- clr_flags pulse -> sat_flag = 0.
REQ-040 The bench SHALL check backpressure:
- o_ready=0, 3 back-to-back products -> first two held in order, third dropped, drop_flag = 1.
- o_ready=1 -> exactly two pops, then o_valid = 0.
REQ-041 The bench SHALL check the sequence error: p_first=1 at phase 2 -> seq_err = 1, no output for the aborted product, and the following 4 terms produce a correct result.
REQ-042 The bench SHALL check reset mid-product: assert rst=0 after term 1 -> o_valid = 0 and flags = 0; after release, a full product yields only its own result.

Source files
------------

// File: rtl/fft_cmul_combine.sv
// Folds four real partial products per complex product into a rounded, saturated result.
// Result enters a 2-deep output FIFO 2 cycles after term 3; no upstream stall, full FIFO drops.
module fft_cmul_combine #(
  parameter int PWIDTH = 36,
  parameter int OWIDTH = 18,
  parameter int SHIFT  = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_valid,
  input  logic                     p_first,
  input  logic signed [PWIDTH-1:0] p,
  input  logic                     clr_flags,
  input  logic                     o_ready,
  output logic                     o_valid,
  output logic signed [OWIDTH-1:0] o_re,
  output logic signed [OWIDTH-1:0] o_im,
  output logic                     sat_flag,
  output logic                     drop_flag,
  output logic                     seq_err
);

  localparam int AW = PWIDTH + 1;
  localparam int RW = PWIDTH + 2;
  localparam logic signed [OWIDTH-1:0] OMAX = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic signed [OWIDTH-1:0] OMIN = {1'b1, {(OWIDTH-1){1'b0}}};
  localparam logic signed [RW-1:0]     MAXV = {{(RW-OWIDTH){1'b0}}, OMAX};
  localparam logic signed [RW-1:0]     MINV = {{(RW-OWIDTH){1'b1}}, OMIN};
  localparam logic signed [RW-1:0]     RND  = RW'(1) << (SHIFT-1);

  // Returns {clipped, value}.
  function automatic logic [OWIDTH:0] scale(input logic signed [AW-1:0] a);
    logic signed [RW-1:0] s;
    s = $signed({a[AW-1], a}) + RND;
    s = s >>> SHIFT;
    if (s > MAXV)      scale = {1'b1, OMAX};
    else if (s < MINV) scale = {1'b1, OMIN};
    else               scale = {1'b0, s[OWIDTH-1:0]};
  endfunction

  logic [1:0]           phase_q;
  logic signed [AW-1:0] acc_re_q, acc_im_q;
  logic                 done_q;
  logic signed [AW-1:0] p_ext;
  logic                 seq_ev;

  assign p_ext  = {p[PWIDTH-1], p};
  assign seq_ev = p_valid && (p_first ? (phase_q != 2'd0) : (phase_q == 2'd0));

  // p_first always restarts at term 0; a stray non-first term at phase 0 is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= 2'd0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (p_valid) begin
        if (p_first) begin
          acc_re_q <= p_ext;
          phase_q  <= 2'd1;
        end else begin
          case (phase_q)
            2'd1: begin acc_re_q <= acc_re_q - p_ext; phase_q <= 2'd2; end
            2'd2: begin acc_im_q <= p_ext;            phase_q <= 2'd3; end
            2'd3: begin
              acc_im_q <= acc_im_q + p_ext;
              phase_q  <= 2'd0;
              done_q   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic [OWIDTH:0]           scl_re, scl_im;
  logic                      sat_ev;
  logic                      rnd_vld_q;
  logic signed [OWIDTH-1:0]  rnd_re_q, rnd_im_q;

  assign scl_re = scale(acc_re_q);
  assign scl_im = scale(acc_im_q);
  assign sat_ev = done_q && (scl_re[OWIDTH] || scl_im[OWIDTH]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_vld_q <= 1'b0;
      rnd_re_q  <= '0;
      rnd_im_q  <= '0;
    end else begin
      rnd_vld_q <= done_q;
      if (done_q) begin
        rnd_re_q <= scl_re[OWIDTH-1:0];
        rnd_im_q <= scl_im[OWIDTH-1:0];
      end
    end
  end

  logic signed [OWIDTH-1:0] mem_re_q [2];
  logic signed [OWIDTH-1:0] mem_im_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               cnt_q, cnt_d;
  logic                     pop, push_ok, drop_ev, full;

  assign o_valid = (cnt_q != 2'd0);
  assign o_re    = mem_re_q[rd_ptr_q];
  assign o_im    = mem_im_q[rd_ptr_q];
  assign full    = (cnt_q == 2'd2);
  assign pop     = o_valid && o_ready;
  // When full, a simultaneous pop frees the head slot that the write pointer targets.
  assign push_ok = rnd_vld_q && (!full || pop);
  assign drop_ev = rnd_vld_q && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push_ok && pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) begin
        mem_re_q[wr_ptr_q] <= rnd_re_q;
        mem_im_q[wr_ptr_q] <= rnd_im_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  logic sat_flag_q, drop_flag_q, seq_err_q;

  // A setting event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag_q  <= 1'b0;
      drop_flag_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      sat_flag_q  <= sat_ev  || (sat_flag_q  && !clr_flags);
      drop_flag_q <= drop_ev || (drop_flag_q && !clr_flags);
      seq_err_q   <= seq_ev  || (seq_err_q   && !clr_flags);
    end
  end

  assign sat_flag  = sat_flag_q;
  assign drop_flag = drop_flag_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_fft_cmul_combine.sv
// Directed bench for fft_cmul_combine with a term-list/queue reference model checked every cycle.
module tb_fft_cmul_combine;
  localparam int PW = 36;
  localparam int OW = 18;
  localparam int SH = 17;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 p_valid = 1'b0;
  logic                 p_first = 1'b0;
  logic signed [PW-1:0] p = '0;
  logic                 clr_flags = 1'b0;
  logic                 o_ready = 1'b1;
  logic                 o_valid;
  logic signed [OW-1:0] o_re, o_im;
  logic                 sat_flag, drop_flag, seq_err;

  fft_cmul_combine #(.PWIDTH(PW), .OWIDTH(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .p_valid(p_valid), .p_first(p_first), .p(p),
    .clr_flags(clr_flags), .o_ready(o_ready), .o_valid(o_valid),
    .o_re(o_re), .o_im(o_im), .sat_flag(sat_flag), .drop_flag(drop_flag),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint re; longint im; } res_t;
  res_t   mq[$];
  res_t   pend[$];
  longint due[$];
  longint satq[$];
  longint terms[4];
  int     tcnt;
  longint cyc;
  bit     m_sat, m_drop, m_seq;
  bit     m_pop, m_push, sev, dev, qev, c1, c2;
  res_t   r;

  function automatic longint floordiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint scale(input longint acc, output bit clip);
    longint v, hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    v = floordiv(acc + (longint'(1) << (SH - 1)), longint'(1) << SH);
    clip = 1'b0;
    if (v > hi) begin v = hi; clip = 1'b1; end
    if (v < lo) begin v = lo; clip = 1'b1; end
    return v;
  endfunction

  initial begin
    tcnt = 0; cyc = 0; m_sat = 0; m_drop = 0; m_seq = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete(); pend.delete(); due.delete(); satq.delete();
        tcnt = 0; cyc = 0; m_sat = 0; m_drop = 0; m_seq = 0;
      end else begin
        cyc++;
        sev = 0; dev = 0; qev = 0; m_push = 0;
        m_pop = (mq.size() > 0) && o_ready;
        while (satq.size() > 0 && satq[0] == cyc) begin
          void'(satq.pop_front());
          sev = 1;
        end
        if (due.size() > 0 && due[0] == cyc) begin
          void'(due.pop_front());
          r = pend.pop_front();
          m_push = 1;
        end
        if (m_push && mq.size() == 2 && !m_pop) dev = 1;
        if (m_pop) void'(mq.pop_front());
        if (m_push && !dev) mq.push_back(r);
        if (p_valid) begin
          if (p_first) begin
            if (tcnt != 0) qev = 1;
            terms[0] = p;
            tcnt = 1;
          end else if (tcnt == 0) begin
            qev = 1;
          end else begin
            terms[tcnt] = p;
            tcnt++;
            if (tcnt == 4) begin
              r.re = scale(terms[0] - terms[1], c1);
              r.im = scale(terms[2] + terms[3], c2);
              pend.push_back(r);
              due.push_back(cyc + 2);
              if (c1 || c2) satq.push_back(cyc + 1);
              tcnt = 0;
            end
          end
        end
        m_sat  = sev || (m_sat  && !clr_flags);
        m_drop = dev || (m_drop && !clr_flags);
        m_seq  = qev || (m_seq  && !clr_flags);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("cyc_o_valid", o_valid, (mq.size() > 0));
        if (mq.size() > 0) begin
          chk("cyc_o_re", o_re, mq[0].re);
          chk("cyc_o_im", o_im, mq[0].im);
        end
        chk("cyc_sat_flag", sat_flag, m_sat);
        chk("cyc_drop_flag", drop_flag, m_drop);
        chk("cyc_seq_err", seq_err, m_seq);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic term(input bit f, input longint a);
    p_valid = 1'b1;
    p_first = f;
    p = a[PW-1:0];
    @(posedge clk); #1;
    p_valid = 1'b0;
    p_first = 1'b0;
    p = '0;
  endtask

  task automatic product(input longint a0, input longint a1, input longint a2, input longint a3);
    term(1'b1, a0);
    term(1'b0, a1);
    term(1'b0, a2);
    term(1'b0, a3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
  endtask

  task automatic expect_one(input string name, input longint re, input longint im);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, o_valid, 1);
    chk({name, "_re"}, o_re, re);
    chk({name, "_im"}, o_im, im);
  endtask

  int     pops;
  longint vals[4];

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_re", o_re, 0);
    chk("rst_o_im", o_im, 0);
    chk("rst_flags", {sat_flag, drop_flag, seq_err}, 0);
    rst = 1'b1;

    // nominal, with exact latency
    product(longint'(1) << 32, 0, 0, 0);
    @(negedge clk); chk("nom_lat0", o_valid, 0);
    @(negedge clk); chk("nom_lat1", o_valid, 0);
    @(negedge clk); chk("nom_lat2", o_valid, 1);
    chk("nom_re", o_re, 32768);
    chk("nom_im", o_im, 0);
    chk("nom_flags", {sat_flag, drop_flag, seq_err}, 0);
    idle(3);

    // rounding
    product(65536, 0, -65537, 0);
    expect_one("rnd_a", 1, -1);
    idle(2);
    product(65535, 0, 0, 0);
    expect_one("rnd_b", 0, 0);
    idle(2);
    product(0, 65536, 0, 0);
    expect_one("rnd_c", 0, 0);
    idle(2);

    // saturation
    product(longint'(1) << 34, 0, -(longint'(1) << 34), -(longint'(1) << 19));
    expect_one("sat", 131071, -131072);
    chk("sat_flag_set", sat_flag, 1);
    idle(1);
    pulse_clr();
    @(negedge clk); chk("sat_flag_clr", sat_flag, 0);
    idle(1);

    // sequence errors: stray term, then abort at phase 2
    term(1'b0, 123);
    @(negedge clk); chk("seq_stray", seq_err, 1);
    idle(1);
    pulse_clr();
    term(1'b1, longint'(5) << 17);
    term(1'b0, 7);
    product(longint'(3) << 17, 0, longint'(2) << 17, 0);
    expect_one("seq", 3, 2);
    chk("seq_err_set", seq_err, 1);
    idle(6);
    @(negedge clk); chk("seq_no_extra", o_valid, 0);
    pulse_clr();

    // backpressure: two held, third dropped, back-to-back products
    o_ready = 1'b0;
    product(longint'(5) << 17, 0, 0, 0);
    product(longint'(6) << 17, 0, 0, 0);
    product(longint'(7) << 17, 0, 0, 0);
    idle(4);
    @(negedge clk);
    chk("bp_drop", drop_flag, 1);
    chk("bp_hold_valid", o_valid, 1);
    chk("bp_hold_re", o_re, 5);
    @(posedge clk); #1;
    o_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_valid && o_ready) begin
        if (pops < 4) vals[pops] = o_re;
        pops++;
      end
    end
    chk("bp_pops", pops, 2);
    chk("bp_first", vals[0], 5);
    chk("bp_second", vals[1], 6);
    chk("bp_empty", o_valid, 0);
    pulse_clr();
    @(negedge clk); chk("bp_drop_clr", drop_flag, 0);
    idle(1);

    // reset mid-product
    term(1'b0, 9);
    term(1'b1, longint'(1) << 32);
    term(1'b0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_re", o_re, 0);
    chk("mid_rst_flags", {sat_flag, drop_flag, seq_err}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    product(longint'(4) << 17, 0, 0, longint'(1) << 17);
    expect_one("post_rst", 4, 1);
    idle(6);
    @(negedge clk); chk("post_rst_only", o_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
